// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, registered fill level and flags,
// optional first-word-fall-through read port, sync flush and sticky error flags.
module sync_fifo #(
  parameter int p_WIDTH    = 1,
  parameter int p_CAPACITY = 4,
  parameter bit p_FWFT     = 1'b0,
  parameter int p_AFULL    = 3,
  parameter int p_AEMPTY   = 1,
  localparam int LW        = $clog2(p_CAPACITY + 1),
  localparam int PW        = (p_CAPACITY > 1) ? $clog2(p_CAPACITY) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic [p_WIDTH-1:0] wrdata,
  input  logic               wrena,
  input  logic               rdena,
  output logic [p_WIDTH-1:0] rddata,
  output logic               rdvalid,
  output logic               full,
  output logic               empty,
  output logic               afull,
  output logic               aempty,
  output logic [LW-1:0]      level,
  output logic               overflow,
  output logic               underflow
);

  logic [p_WIDTH-1:0] mem [0:p_CAPACITY-1];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level_nxt;
  logic               clear, wr_acc, rd_acc;

  assign clear  = ~rstn | flush;
  // Acceptance uses the registered flags, so a write at full is dropped even
  // when a read frees a slot in the same cycle.
  assign wr_acc = wrena & ~full  & ~clear;
  assign rd_acc = rdena & ~empty & ~clear;

  always_comb begin
    level_nxt = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= (wr_ptr == PW'(p_CAPACITY - 1)) ? '0 : wr_ptr + PW'(1);
      if (rd_acc)
        rd_ptr <= (rd_ptr == PW'(p_CAPACITY - 1)) ? '0 : rd_ptr + PW'(1);
      level     <= level_nxt;
      full      <= (level_nxt == LW'(p_CAPACITY));
      empty     <= (level_nxt == '0);
      afull     <= (level_nxt >= LW'(p_AFULL));
      aempty    <= (level_nxt <= LW'(p_AEMPTY));
      if (wrena && full)
        overflow <= 1'b1;
      if (rdena && empty)
        underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; a word is only ever read after it
  // has been written, so clearing it would cost logic for no behaviour.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wrdata;
  end

  generate
    if (p_FWFT) begin : g_fwft
      // Head word shown while non-empty; forced to zero otherwise so the
      // output never exposes stale or uninitialised storage.
      assign rdvalid = ~empty;
      assign rddata  = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [p_WIDTH-1:0] rddata_q;
      logic               rdvalid_q;

      always_ff @(posedge clk) begin
        if (clear) begin
          rddata_q  <= '0;
          rdvalid_q <= 1'b0;
        end else begin
          rdvalid_q <= rd_acc;
          if (rd_acc)
            rddata_q <= mem[rd_ptr];
        end
      end

      assign rddata  = rddata_q;
      assign rdvalid = rdvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: a registered-read and an FWFT instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int W   = 8;
  localparam int CAP = 5;
  localparam int AF  = 3;
  localparam int AE  = 1;
  localparam int LW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0, flush = 1'b0, wrena = 1'b0, rdena = 1'b0;
  logic [W-1:0]  wrdata = '0;

  logic [W-1:0]  rddata0, rddata1;
  logic          rdvalid0, rdvalid1, full0, full1, empty0, empty1;
  logic          afull0, afull1, aempty0, aempty1, ovf0, ovf1, unf0, unf1;
  logic [LW-1:0] level0, level1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_rv;
  logic [W-1:0] m_rd;

  always #5 clk = ~clk;

  sync_fifo #(.p_WIDTH(W), .p_CAPACITY(CAP), .p_FWFT(1'b0), .p_AFULL(AF), .p_AEMPTY(AE)) dut0 (
    .clk(clk), .rstn(rstn), .flush(flush), .wrdata(wrdata), .wrena(wrena), .rdena(rdena),
    .rddata(rddata0), .rdvalid(rdvalid0), .full(full0), .empty(empty0), .afull(afull0),
    .aempty(aempty0), .level(level0), .overflow(ovf0), .underflow(unf0));

  sync_fifo #(.p_WIDTH(W), .p_CAPACITY(CAP), .p_FWFT(1'b1), .p_AFULL(AF), .p_AEMPTY(AE)) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush), .wrdata(wrdata), .wrena(wrena), .rdena(rdena),
    .rddata(rddata1), .rdvalid(rdvalid1), .full(full1), .empty(empty1), .afull(afull1),
    .aempty(aempty1), .level(level1), .overflow(ovf1), .underflow(unf1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int n;
    bit wacc, racc;
    n = q.size();
    if (!rstn || flush) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
      return;
    end
    wacc = wrena && (n < CAP);
    racc = rdena && (n > 0);
    if (wrena && n == CAP) m_ovf = 1;
    if (rdena && n == 0)   m_unf = 1;
    m_rv = racc;
    if (racc) m_rd = q.pop_front();
    if (wacc) q.push_back(wrdata);
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("level0",   32'(level0),   32'(n));
    check("full0",    32'(full0),    32'(n == CAP));
    check("empty0",   32'(empty0),   32'(n == 0));
    check("afull0",   32'(afull0),   32'(n >= AF));
    check("aempty0",  32'(aempty0),  32'(n <= AE));
    check("ovf0",     32'(ovf0),     32'(m_ovf));
    check("unf0",     32'(unf0),     32'(m_unf));
    check("rdvalid0", 32'(rdvalid0), 32'(m_rv));
    check("rddata0",  32'(rddata0),  32'(m_rd));
    check("level1",   32'(level1),   32'(n));
    check("ovf1",     32'(ovf1),     32'(m_ovf));
    check("unf1",     32'(unf1),     32'(m_unf));
    check("rdvalid1", 32'(rdvalid1), 32'(n != 0));
    if (n != 0) check("rddata1", 32'(rddata1), 32'(q[0]));
  endtask

  task automatic step(input bit rst_n, input bit fl, input bit wr, input bit rd, input logic [W-1:0] d);
    @(negedge clk);
    rstn = rst_n; flush = fl; wrena = wr; rdena = rd; wrdata = d;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, '0);
    step(0, 0, 1, 1, 8'hFF);
    check("rst_rddata0", 32'(rddata0), 32'h0);

    // Fill 0x01..0x05, then a dropped 6th write
    for (int i = 1; i <= 5; i++) step(1, 0, 1, 0, W'(i));
    check("t1_full", 32'(full0), 32'd1);
    step(1, 0, 1, 0, 8'h66);
    check("t1_ovf", 32'(ovf0), 32'd1);

    // Drain; registered data appears one cycle after rdena
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 1, '0);
      check("t2_data", 32'(rddata0), 32'(i));
    end
    step(1, 0, 0, 1, '0);
    check("t2_unf", 32'(unf0), 32'd1);
    check("t2_rv_drop", 32'(rdvalid0), 32'd0);

    // Wrap: hold level at 2 through 12 write/read pairs
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, 8'h10);
    step(1, 0, 1, 0, 8'h11);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, 1, W'(8'h12 + i));
      check("t3_level", 32'(level0), 32'd2);
    end

    // Simultaneous wr/rd at full and at empty
    step(1, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, W'(8'h40 + i));
    step(1, 0, 1, 1, 8'h77);
    check("t4_full_level", 32'(level0), 32'd4);
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 1, 8'h55);
    check("t4_empty_level", 32'(level0), 32'd1);
    check("t4_unf", 32'(unf0), 32'd1);

    // FWFT fall-through, then pop
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, 8'hA5);
    check("t5_fwft_data", 32'(rddata1), 32'hA5);
    step(1, 0, 0, 1, '0);
    check("t5_fwft_empty", 32'(empty1), 32'd1);

    // Flush with level 3 and a concurrent write; reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, W'(8'hC0 + i));
    step(1, 0, 1, 0, 8'hC3);
    step(1, 0, 0, 1, '0);
    step(1, 1, 1, 0, 8'hEE);
    check("t6_flush_level", 32'(level0), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, W'(8'hD0 + i));
    step(0, 1, 1, 1, 8'hDD);
    check("t6_rst_empty", 32'(empty0), 32'd1);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      bit r, f, wr, rd;
      r  = ($urandom_range(0, 99) != 0);
      f  = ($urandom_range(0, 59) == 0);
      wr = ($urandom_range(0, 99) < ((i / 100) % 2 ? 70 : 40));
      rd = ($urandom_range(0, 99) < ((i / 100) % 2 ? 40 : 70));
      step(r, f, wr, rd, W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
